muldiv_unit: RTL
================

# muldiv_unit

Parametrised iterative multiply/divide unit for the RV32IM pipeline's EX stage. It replaces the single-cycle M-extension path in the ALU with a multi-cycle engine that has a start/done handshake, a kill input for branch flushes, and a destination-tag passthrough for writeback. The hazard logic stalls IF/ID/EX while `BUSY` is high.

## Interface
- `XLEN`, default 32: operand and result width; must be ≥ 4.
- `TAG_W`, default 5: width of the destination-register tag carried alongside the operation.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `START` in 1: request; sampled only when the state is IDLE or DONE.
- `KILL` in 1: abort the in-flight operation (pipeline flush).
- `OP` in 3: RISC-V funct3 encoding. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `DATA1` in XLEN: rs1 operand (multiplicand or dividend).
- `DATA2` in XLEN: rs2 operand (multiplier or divisor).
- `TAG_IN` in TAG_W: destination tag, captured with `START`.
- `BUSY` out 1: high in the ITER and FIX states.
- `DONE` out 1: one-cycle pulse; `RESULT` and `TAG_OUT` are valid from this cycle onward.
- `RESULT` out XLEN: result; held until the next completion.
- `TAG_OUT` out TAG_W: tag of the completed operation; held with `RESULT`.

## Operation
- States: IDLE, ITER, FIX, DONE.
- Reset values: state IDLE, `BUSY`=0, `DONE`=0, `RESULT`=0, `TAG_OUT`=0, iteration counter=0.
- **Accept.** `START`=1 in IDLE or DONE with `KILL`=0 latches `OP`, `TAG_IN`, sign flags and operand magnitudes.
  - Signed operands: MULH takes both signed; MULHSU takes `DATA1` signed only; DIV and REM take both signed.
  - Next state is ITER with counter=0, except on a fast path.
- **Fast paths**, taken directly to DONE on the accept edge:
  - Divide by zero: quotient = all ones; remainder = `DATA1`.
  - DIV/REM with `DATA1` = signed minimum and `DATA2` = −1: quotient = signed minimum; remainder = 0.
- **ITER, multiply.** One shift-add step per cycle over a 2·XLEN-bit accumulator of unsigned magnitudes.
- **ITER, divide.** One restoring step per cycle producing 1 quotient bit, with an XLEN+1-bit partial remainder.
- **Counter.** Increments each ITER cycle. When the counter equals XLEN−1 on an edge, the next state is FIX.
- **FIX.** Applies sign correction (two's-complement negate) and selects the result:
  - Product sign = sign1 XOR sign2.
  - Quotient sign = sign1 XOR sign2.
  - Remainder sign = sign of the dividend.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
  - Writes `RESULT`/`TAG_OUT` and moves to DONE.
- **DONE.** `DONE`=1 for exactly one cycle. Next state is IDLE, or the accept path if `START`=1 (back-to-back operation).
- **KILL.** `KILL`=1 on an edge in any state forces IDLE.
  - No `DONE` pulse is produced; `RESULT`/`TAG_OUT` are unchanged.
  - `KILL` beats `START` when both are high in the same cycle.
- **START while busy.** `START` in ITER or FIX is ignored; no queuing.
- **RESET priority.** `RESET` beats `KILL` and `START`. Asserting it mid-operation returns all outputs to their reset values at the next edge.

## Timing
- Take `START` high in cycle 0 (accept edge at the end of cycle 0).
- Normal latency: `BUSY`=1 in cycles 1..XLEN+1 (XLEN ITER cycles plus 1 FIX cycle). `DONE`=1 and `RESULT` are valid in cycle XLEN+2 (cycle 34 for XLEN=32).
- Fast path: `DONE`=1 in cycle 1 and `BUSY` stays 0.
- Back-to-back: `START` in the DONE cycle (cycle XLEN+2) gives `BUSY`=1 in cycle XLEN+3. Throughput is one operation per XLEN+2 cycles.
- `BUSY` and `DONE` are registered outputs with no combinational path from any input.
- Operand inputs are don't-care after the accept edge.

## Test plan
All scenarios use XLEN=32 and TAG_W=5.
1. MUL 7 × 0xFFFFFFFD (−3), `TAG_IN`=9 → `BUSY` high in cycles 1–33, `DONE` in cycle 34, `RESULT`=0xFFFFFFEB, `TAG_OUT`=9.
2. High-half multiplies:
   - MULH 0x80000000 × 0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
   - Issue all three back-to-back, each `START` in the previous `DONE` cycle; `DONE` pulses every 34 cycles.
3. Divide and remainder:
   - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
   - REM −7 / 2 → 0xFFFFFFFF.
   - DIVU 100 / 7 → 14.
   - REMU 100 / 7 → 2.
4. Fast paths:
   - DIVU 5 / 0 → 0xFFFFFFFF with `DONE` in cycle 1.
   - REM 5 / 0 → 5.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
   - REM of the same operands → 0.
   - `BUSY` never rises in any of these.
5. KILL and START-while-busy:
   - DIV started, then `KILL` in cycle 10 → `BUSY`=0 in cycle 11, no `DONE`, `RESULT` retains its prior value.
   - MUL 3 × 4 with `START` in cycle 11 → `DONE` in cycle 45, `RESULT`=12.
   - `START` pulsed during ITER is ignored.
6. Reset and priority:
   - `RESET` in cycle 20 of a MULHU → all outputs 0 in cycle 21, state IDLE.
   - `KILL` and `START` high together in IDLE → no accept.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Start/done handshake bundle between the EX stage and the iterative multiply/divide unit.
// The slave side is the unit; the master side is the pipeline issuing operations.
interface muldiv_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) ();

    logic             START;
    logic             KILL;
    logic [2:0]       OP;
    logic [XLEN-1:0]  DATA1;
    logic [XLEN-1:0]  DATA2;
    logic [TAG_W-1:0] TAG_IN;
    logic             BUSY;
    logic             DONE;
    logic [XLEN-1:0]  RESULT;
    logic [TAG_W-1:0] TAG_OUT;

    modport master (
        output START, KILL, OP, DATA1, DATA2, TAG_IN,
        input  BUSY, DONE, RESULT, TAG_OUT
    );

    modport slave (
        input  START, KILL, OP, DATA1, DATA2, TAG_IN,
        output BUSY, DONE, RESULT, TAG_OUT
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: shift-add multiply, restoring divide,
// one bit per cycle, with divide fast paths, flush kill and writeback tag passthrough.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input logic          CLK,
    input logic          RESET,
    muldiv_unit_if.slave bus
);

    localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam int unsigned ACC_W = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic             neg1_q;
    logic             neg2_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  opnd_q;
    logic [ACC_W-1:0] acc_q;
    logic [XLEN:0]    rem_q;
    logic             busy_q;
    logic             done_q;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] tag_out_q;

    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.RESULT  = result_q;
    assign bus.TAG_OUT = tag_out_q;

    // Operand decode on the accept edge: sign flags, magnitudes and fast-path results
    logic            signed1_c;
    logic            signed2_c;
    logic            neg1_c;
    logic            neg2_c;
    logic            div_zero_c;
    logic            div_ovf_c;
    logic            fast_c;
    logic [XLEN-1:0] mag1_c;
    logic [XLEN-1:0] mag2_c;
    logic [XLEN-1:0] fast_res_c;

    always_comb begin
        signed1_c  = (bus.OP == OP_MULH) || (bus.OP == OP_MULHSU) ||
                     (bus.OP == OP_DIV)  || (bus.OP == OP_REM);
        signed2_c  = (bus.OP == OP_MULH) || (bus.OP == OP_DIV) || (bus.OP == OP_REM);
        neg1_c     = signed1_c && bus.DATA1[XLEN-1];
        neg2_c     = signed2_c && bus.DATA2[XLEN-1];
        mag1_c     = neg1_c ? -bus.DATA1 : bus.DATA1;
        mag2_c     = neg2_c ? -bus.DATA2 : bus.DATA2;
        div_zero_c = bus.OP[2] && (bus.DATA2 == '0);
        div_ovf_c  = ((bus.OP == OP_DIV) || (bus.OP == OP_REM)) &&
                     (bus.DATA1 == SMIN) && (bus.DATA2 == '1);
        fast_c     = div_zero_c || div_ovf_c;
        fast_res_c = '0;
        if (div_zero_c) begin
            fast_res_c = bus.OP[1] ? bus.DATA1 : '1;
        end else if (div_ovf_c) begin
            fast_res_c = bus.OP[1] ? '0 : SMIN;
        end
    end

    // One iteration step: multiply adds into the high half, divide shifts in a dividend bit
    logic [XLEN:0] mul_sum_c;
    logic [XLEN:0] div_shift_c;
    logic [XLEN:0] div_diff_c;
    logic          div_ge_c;

    always_comb begin
        mul_sum_c   = {1'b0, acc_q[ACC_W-1:XLEN]} + {1'b0, opnd_q};
        div_shift_c = (rem_q << 1) | {{XLEN{1'b0}}, acc_q[XLEN-1]};
        div_ge_c    = div_shift_c >= {1'b0, opnd_q};
        div_diff_c  = div_shift_c - {1'b0, opnd_q};
    end

    // Sign correction and result selection for the FIX cycle
    logic [ACC_W-1:0] prod_c;
    logic [XLEN-1:0]  quot_c;
    logic [XLEN-1:0]  remd_c;
    logic [XLEN-1:0]  fix_res_c;

    always_comb begin
        prod_c = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
        quot_c = (neg1_q ^ neg2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        remd_c = neg1_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        case (op_q)
            OP_MUL:                       fix_res_c = prod_c[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_c = prod_c[ACC_W-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res_c = quot_c;
            default:                      fix_res_c = remd_c;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            tag_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else if (bus.KILL) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.START) begin
                        op_q   <= bus.OP;
                        neg1_q <= neg1_c;
                        neg2_q <= neg2_c;
                        tag_q  <= bus.TAG_IN;
                        cnt_q  <= '0;
                        rem_q  <= '0;
                        // Divide keeps the dividend in the low half; multiply keeps the multiplier there
                        acc_q  <= {{XLEN{1'b0}}, bus.OP[2] ? mag1_c : mag2_c};
                        opnd_q <= bus.OP[2] ? mag2_c : mag1_c;
                        if (fast_c) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            result_q  <= fast_res_c;
                            tag_out_q <= bus.TAG_IN;
                        end else begin
                            state_q <= S_ITER;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (op_q[2]) begin
                        rem_q <= div_ge_c ? div_diff_c : div_shift_c;
                        acc_q <= {acc_q[ACC_W-1:XLEN], acc_q[XLEN-2:0], div_ge_c};
                    end else if (acc_q[0]) begin
                        acc_q <= {mul_sum_c, acc_q[XLEN-1:1]};
                    end else begin
                        acc_q <= {1'b0, acc_q[ACC_W-1:1]};
                    end
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q   <= S_DONE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    result_q  <= fix_res_c;
                    tag_out_q <= tag_q;
                    cnt_q     <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
